dma_wr_dest_engine: RTL and testbench

Parametrised DMA destination write engine. Accepts one descriptor at a time (destination address plus length in beats) and drains the read-data FIFO onto an AXI4 write channel. It splits each transfer into INCR bursts bounded by a maximum burst length and by 4 KB boundaries, and keeps up to MAX_OUTSTANDING write responses in flight. It sits between the descriptor dispatcher and the destination memory port, and reports busy/done/error plus performance counters to the CSR block.

---
 rtl/dma_wr_dest_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_dma_wr_dest_engine.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_wr_dest_engine.sv
// rtl/dma_wr_dest_engine.sv - DMA destination write engine: descriptor to AXI4 INCR write bursts
module dma_wr_dest_engine #(
  parameter int DATA_W          = 512,
  parameter int ADDR_W          = 64,
  parameter int LENGTH_W        = 24,
  parameter int MAX_BURST_BEATS = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PERF_CNTR_W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [ADDR_W-1:0]      desc_dest_addr,
  input  logic [LENGTH_W-1:0]    desc_length,
  input  logic                   fifo_not_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_W-1:0]      fifo_rd_data,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [DATA_W-1:0]      wdata,
  output logic [DATA_W/8-1:0]    wstrb,
  output logic                   wlast,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  input  logic                   clear_error,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_resp,
  output logic [PERF_CNTR_W-1:0] clk_cnt,
  output logic [PERF_CNTR_W-1:0] beat_cnt
);

  localparam int BEAT_BYTES = DATA_W / 8;
  localparam int SIZE       = $clog2(BEAT_BYTES);
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  // Common width for the burst-size minimum: wide enough for length and for beats-to-4KB.
  localparam int CW         = (LENGTH_W > 13) ? LENGTH_W : 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN,
    ST_ERROR
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q;
  logic [LENGTH_W-1:0]  remaining_q;
  logic [ADDR_W-1:0]    awaddr_q;
  logic [7:0]           awlen_q;
  logic                 awvalid_q;
  logic [8:0]           burst_q;
  logic [8:0]           beats_left_q;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic                 error_q;
  logic [1:0]           err_resp_q;
  logic                 done_q;
  logic [PERF_CNTR_W-1:0] clk_cnt_q, beat_cnt_q;

  logic [ADDR_W-1:0]    desc_addr_aligned;
  logic [ADDR_W-1:0]    src_addr;
  logic [LENGTH_W-1:0]  src_rem;
  logic [12:0]          beats_to_4k;
  logic [CW-1:0]        rem_ext, cap_ext, burst_ext;
  logic                 aw_hs, w_hs, b_hs, err_now, desc_accept, enter_addr;

  assign desc_addr_aligned = desc_dest_addr & ~ADDR_W'(BEAT_BYTES - 1);
  assign aw_hs       = awvalid_q & awready;
  assign w_hs        = fifo_rd_en;
  assign b_hs        = bvalid;
  // A failing response seen this very cycle must already block further AW issue.
  assign err_now     = error_q | (bvalid & bresp[1]);
  assign desc_accept = (state_q == ST_IDLE) & desc_valid;
  assign enter_addr  = (state_d == ST_ADDR) & (state_q != ST_ADDR);
  assign outstanding_d = outstanding_q + OUT_W'(aw_hs) - OUT_W'(b_hs);

  // Next burst size: the descriptor in IDLE, otherwise the running address/remaining count.
  always_comb begin
    src_addr    = (state_q == ST_IDLE) ? desc_addr_aligned : addr_q;
    src_rem     = (state_q == ST_IDLE) ? desc_length : remaining_q;
    beats_to_4k = (13'd4096 - {1'b0, src_addr[11:0]}) >> SIZE;
    rem_ext     = CW'(src_rem);
    cap_ext     = (CW'(beats_to_4k) < CW'(MAX_BURST_BEATS)) ? CW'(beats_to_4k) : CW'(MAX_BURST_BEATS);
    burst_ext   = (rem_ext < cap_ext) ? rem_ext : cap_ext;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and W-channel / descriptor handshake outputs.
  always_comb begin
    state_d    = state_q;
    desc_ready = 1'b0;
    wvalid     = 1'b0;
    wlast      = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) begin
          state_d = (desc_length == '0) ? ST_DRAIN : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          state_d = ST_DATA;
        end else if (!awvalid_q && err_now) begin
          // AW not yet presented: abandon the rest of the transfer.
          state_d = ST_DRAIN;
        end
      end
      ST_DATA: begin
        wvalid     = fifo_not_empty;
        wlast      = (beats_left_q == 9'd1);
        fifo_rd_en = fifo_not_empty & wready;
        if (fifo_not_empty && wready && (beats_left_q == 9'd1)) begin
          state_d = ((remaining_q != '0) && !err_now) ? ST_ADDR : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = err_now ? ST_ERROR : ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (clear_error) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Count AW bursts still waiting for their B response.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  // AW channel: load burst on ADDR entry, raise awvalid a cycle later when a slot is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      awaddr_q  <= '0;
      awlen_q   <= '0;
      burst_q   <= '0;
      awvalid_q <= 1'b0;
    end else begin
      if (enter_addr) begin
        awaddr_q <= src_addr;
        awlen_q  <= 8'(burst_ext - CW'(1));
        burst_q  <= 9'(burst_ext);
      end
      if (aw_hs) begin
        awvalid_q <= 1'b0;
      end else if ((state_q == ST_ADDR) && !awvalid_q && !err_now &&
                   (outstanding_q < OUT_W'(MAX_OUTSTANDING))) begin
        awvalid_q <= 1'b1;
      end
    end
  end

  // Transfer progress: running address, beats remaining, beats left in the current burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
    end else begin
      if (desc_accept) begin
        addr_q      <= desc_addr_aligned;
        remaining_q <= desc_length;
      end
      if (aw_hs) begin
        addr_q       <= addr_q + (ADDR_W'(burst_q) << SIZE);
        remaining_q  <= remaining_q - LENGTH_W'(burst_q);
        beats_left_q <= burst_q;
      end else if (w_hs) begin
        beats_left_q <= beats_left_q - 9'd1;
      end
    end
  end

  // Sticky error capture; only the first failing response code is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q    <= 1'b0;
      err_resp_q <= 2'b00;
    end else if ((state_q == ST_ERROR) && clear_error) begin
      error_q    <= 1'b0;
      err_resp_q <= 2'b00;
    end else if (bvalid && bresp[1] && !error_q) begin
      error_q    <= 1'b1;
      err_resp_q <= bresp;
    end
  end

  // Completion pulse and per-transfer performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q     <= 1'b0;
      clk_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      done_q <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
      if (desc_accept) begin
        clk_cnt_q  <= '0;
        beat_cnt_q <= '0;
      end else begin
        if (state_q != ST_IDLE) begin
          clk_cnt_q <= clk_cnt_q + PERF_CNTR_W'(1);
        end
        if (w_hs) begin
          beat_cnt_q <= beat_cnt_q + PERF_CNTR_W'(1);
        end
      end
    end
  end

  assign awvalid  = awvalid_q;
  assign awaddr   = awaddr_q;
  assign awlen    = awlen_q;
  assign awsize   = 3'(SIZE);
  assign awburst  = 2'b01;
  assign wdata    = fifo_rd_data;
  assign wstrb    = '1;
  assign bready   = 1'b1;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign err_resp = err_resp_q;
  assign clk_cnt  = clk_cnt_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_dma_wr_dest_engine.sv
// tb/tb_dma_wr_dest_engine.sv - self-checking bench for dma_wr_dest_engine
module tb_dma_wr_dest_engine;
  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;
  localparam int LENGTH_W = 24;
  localparam int PW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, desc_valid, desc_ready;
  logic [ADDR_W-1:0] desc_dest_addr;
  logic [LENGTH_W-1:0] desc_length;
  logic fifo_not_empty, fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic bvalid, bready;
  logic [1:0] bresp;
  logic clear_error, busy, done, error;
  logic [1:0] err_resp;
  logic [PW-1:0] clk_cnt, beat_cnt;

  dma_wr_dest_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LENGTH_W(LENGTH_W),
    .MAX_BURST_BEATS(64), .MAX_OUTSTANDING(4), .PERF_CNTR_W(PW)
  ) dut (
    .clk(clk), .reset(reset),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_dest_addr(desc_dest_addr), .desc_length(desc_length),
    .fifo_not_empty(fifo_not_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .clear_error(clear_error), .busy(busy), .done(done), .error(error),
    .err_resp(err_resp), .clk_cnt(clk_cnt), .beat_cnt(beat_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit agent_gaps = 0;
  bit b_hold = 0;
  int err_b_idx = -1;
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  logic [63:0] exp_aw_addr[$];
  logic [63:0] act_aw_addr[$];
  int exp_aw_len[$];
  int act_aw_len[$];
  int aw_seen = 0, w_seen = 0, b_seen = 0, done_seen = 0;
  int b_pending = 0, w_burst_idx = 0, beat_in_burst = 0;

  typedef struct {
    logic [63:0] addr;
    int len;
    bit gaps;
    int naw;
    logic [63:0] aw0;
    int len0;
    logic [63:0] awl;
    int lenl;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // AXI slave, FIFO source and protocol monitor: drive at negedge, observe 1 time unit later.
  initial begin
    bit pop_pending, fifo_avail, prev_aw_wait, prev_w_wait, exp_last;
    logic [63:0] prev_awaddr;
    logic [7:0] prev_awlen;
    logic [DATA_W-1:0] prev_wdata;
    pop_pending = 0; fifo_avail = 0; prev_aw_wait = 0; prev_w_wait = 0;
    prev_awaddr = '0; prev_awlen = '0; prev_wdata = '0;
    fifo_not_empty = 0; fifo_rd_data = '0; awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_avail = 0;
        pop_pending = 0;
      end
      // A real FIFO never goes empty without a pop, so availability is sticky until popped.
      if (!fifo_avail && fifo_q.size() > 0) fifo_avail = agent_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (fifo_q.size() == 0) fifo_avail = 0;
      fifo_not_empty = fifo_avail;
      fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      wready = agent_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      awready = agent_gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      bvalid = !b_hold && (b_pending > 0) && (agent_gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      bresp = (b_seen == err_b_idx) ? 2'b10 : 2'b00;
      #1;
      if (prev_aw_wait) begin
        chk("aw_hold_valid", awvalid, 1);
        chk("aw_hold_addr", awaddr, prev_awaddr);
        chk("aw_hold_len", awlen, prev_awlen);
      end
      if (prev_w_wait) begin
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_data", wdata, prev_wdata);
      end
      if (wvalid) begin
        chk("wvalid_needs_fifo", fifo_not_empty, 1);
        chk("rd_en_rule", fifo_rd_en, wready);
      end
      if (awvalid && awready) begin
        if (aw_seen < exp_aw_addr.size()) begin
          chk("awaddr", awaddr, exp_aw_addr[aw_seen]);
          chk("awlen", awlen, exp_aw_len[aw_seen]);
        end else begin
          chk("extra_aw", aw_seen, exp_aw_addr.size());
        end
        chk("awsize", awsize, 6);
        chk("awburst", awburst, 1);
        chk("aw_no_4k_cross", ((awaddr & 64'd4095) + (64'(awlen) + 64'd1) * 64'd64) <= 64'd4096, 1);
        chk("outstanding_limit", (aw_seen - b_seen) < 4, 1);
        act_aw_addr.push_back(awaddr);
        act_aw_len.push_back(int'(awlen));
        aw_seen++;
      end
      if (wvalid && wready) begin
        exp_last = 0;
        if (w_burst_idx < exp_aw_len.size()) exp_last = (beat_in_burst == exp_aw_len[w_burst_idx]);
        if (w_seen < exp_data_q.size()) chk("wdata_order", wdata, exp_data_q[w_seen]);
        else chk("extra_w_beat", w_seen, exp_data_q.size());
        chk("wlast", wlast, exp_last);
        chk("wstrb", wstrb, {(DATA_W/8){1'b1}});
        if (exp_last) begin
          w_burst_idx++;
          beat_in_burst = 0;
          b_pending++;
        end else begin
          beat_in_burst++;
        end
        w_seen++;
      end
      if (bvalid) begin
        chk("bready", bready, 1);
        b_seen++;
        b_pending--;
      end
      if (done) begin
        done_seen++;
        chk("done_after_all_b", b_seen, exp_aw_addr.size());
        chk("done_after_all_w", w_seen, exp_data_q.size());
      end
      pop_pending = fifo_rd_en;
      prev_aw_wait = awvalid && !awready;
      prev_awaddr = awaddr;
      prev_awlen = awlen;
      prev_w_wait = wvalid && !wready;
      prev_wdata = wdata;
    end
  end

  // Reference model: split the descriptor into bursts, present it, leave the bench waiting.
  task automatic start_desc(input logic [63:0] addr, input int len, input bit gaps);
    logic [63:0] a;
    logic [DATA_W-1:0] d;
    int rem, to4k, b;
    exp_aw_addr.delete(); exp_aw_len.delete(); exp_data_q.delete(); fifo_q.delete();
    act_aw_addr.delete(); act_aw_len.delete();
    a = addr & ~64'h3F;
    rem = len;
    while (rem > 0) begin
      to4k = (4096 - int'(a % 64'd4096)) / 64;
      b = rem;
      if (b > 64) b = 64;
      if (b > to4k) b = to4k;
      exp_aw_addr.push_back(a);
      exp_aw_len.push_back(b - 1);
      a = a + 64'(b * 64);
      rem = rem - b;
    end
    for (int i = 0; i < len; i++) begin
      d = rand_beat();
      fifo_q.push_back(d);
      exp_data_q.push_back(d);
    end
    aw_seen = 0; w_seen = 0; b_seen = 0; done_seen = 0;
    b_pending = 0; w_burst_idx = 0; beat_in_burst = 0;
    agent_gaps = gaps;
    @(negedge clk);
    desc_valid = 1; desc_dest_addr = addr; desc_length = 24'(len);
    #2;
    chk("desc_ready_idle", desc_ready, 1);
    @(negedge clk);
    desc_valid = 0;
  endtask

  task automatic finish_desc(input int len);
    for (int c = 0; c < 20000 && done_seen == 0; c++) begin
      @(negedge clk); #2;
    end
    @(negedge clk); #2;
    chk("done_single_pulse", done_seen, 1);
    chk("aw_count", aw_seen, exp_aw_addr.size());
    chk("w_count", w_seen, len);
    chk("b_count", b_seen, exp_aw_addr.size());
    chk("beat_cnt", beat_cnt, len);
    chk("busy_after_done", busy, 0);
    chk("error_clear", error, 0);
    if (len == 0) chk("clk_cnt_len0", clk_cnt, 1);
    else chk("clk_cnt_bound", clk_cnt >= 64'(len + exp_aw_addr.size()), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; desc_valid = 0; desc_dest_addr = '0; desc_length = '0; clear_error = 0;
    vecs[0] = '{addr:64'h1000, len:64,  gaps:1'b0, naw:1, aw0:64'h1000, len0:63, awl:64'h1000, lenl:63};
    vecs[1] = '{addr:64'h1F00, len:10,  gaps:1'b0, naw:2, aw0:64'h1F00, len0:3,  awl:64'h2000, lenl:5};
    vecs[2] = '{addr:64'h0,    len:200, gaps:1'b0, naw:4, aw0:64'h0,    len0:63, awl:64'h3000, lenl:7};
    vecs[3] = '{addr:64'h2000, len:32,  gaps:1'b1, naw:1, aw0:64'h2000, len0:31, awl:64'h2000, lenl:31};
    vecs[4] = '{addr:64'h500,  len:0,   gaps:1'b0, naw:0, aw0:64'h0,    len0:0,  awl:64'h0,    lenl:0};
    vecs[5] = '{addr:64'h1FC7, len:3,   gaps:1'b1, naw:2, aw0:64'h1FC0, len0:0,  awl:64'h2000, lenl:1};
    vecs[6] = '{addr:64'h0FC0, len:130, gaps:1'b1, naw:4, aw0:64'h0FC0, len0:0,  awl:64'h3000, lenl:0};

    repeat (3) @(negedge clk);
    #2;
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_err_resp", err_resp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clk_cnt", clk_cnt, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awlen", awlen, 0);
    chk("rst_desc_ready", desc_ready, 1);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 7; i++) begin
      start_desc(vecs[i].addr, vecs[i].len, vecs[i].gaps);
      finish_desc(vecs[i].len);
      chk("vec_naw", act_aw_addr.size(), vecs[i].naw);
      if (vecs[i].naw > 0 && act_aw_addr.size() > 0) begin
        chk("vec_first_awaddr", act_aw_addr[0], vecs[i].aw0);
        chk("vec_first_awlen", act_aw_len[0], vecs[i].len0);
        chk("vec_last_awaddr", act_aw_addr[act_aw_addr.size()-1], vecs[i].awl);
        chk("vec_last_awlen", act_aw_len[act_aw_len.size()-1], vecs[i].lenl);
      end
    end

    for (int r = 0; r < 5; r++) begin
      logic [63:0] ra;
      int rl;
      ra = 64'($urandom_range(0, 32'hFFFFF));
      rl = $urandom_range(0, 260);
      start_desc(ra, rl, 1'b1);
      finish_desc(rl);
    end

    // Outstanding limit: with responses withheld only four bursts may be issued.
    b_hold = 1;
    start_desc(64'h0, 320, 1'b0);
    for (int c = 0; c < 5000 && !(aw_seen == 4 && w_seen == 256); c++) begin
      @(negedge clk); #2;
    end
    repeat (20) @(negedge clk);
    #2;
    chk("ost_aw_count", aw_seen, 4);
    chk("ost_awvalid_low", awvalid, 0);
    chk("ost_busy", busy, 1);
    chk("ost_no_done", done_seen, 0);
    b_hold = 0;
    finish_desc(320);

    // Error: SLVERR on the first response, returned while burst 2 is streaming.
    err_b_idx = 0;
    b_hold = 1;
    start_desc(64'h0, 192, 1'b0);
    for (int c = 0; c < 2000 && aw_seen < 2; c++) begin
      @(negedge clk); #2;
    end
    b_hold = 0;
    for (int c = 0; c < 2000 && b_seen < 2; c++) begin
      @(negedge clk); #2;
    end
    repeat (20) @(negedge clk);
    #2;
    chk("err_aw_count", aw_seen, 2);
    chk("err_w_count", w_seen, 128);
    chk("err_flag", error, 1);
    chk("err_resp", err_resp, 2);
    chk("err_no_done", done_seen, 0);
    chk("err_busy", busy, 1);
    chk("err_desc_ready", desc_ready, 0);
    clear_error = 1;
    @(negedge clk);
    clear_error = 0;
    #2;
    chk("clr_busy", busy, 0);
    chk("clr_desc_ready", desc_ready, 1);
    chk("clr_error", error, 0);
    chk("clr_err_resp", err_resp, 0);
    chk("clr_no_done", done, 0);
    err_b_idx = -1;
    fifo_q.delete();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
